// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and frame constants for the UART boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        RUN,
        ERROR
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_W             = 16;
    localparam int         WORD_W            = 32;
    localparam int         BYTES_PER_WORD    = 4;

    function automatic logic in_frame(input boot_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == WRITE) || (s == CHECK);
    endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - little-endian byte-to-word packer with a one-byte holding register
module boot_word_assembler
    import boot_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_flush,
    input  logic              i_shift_en,
    input  logic              i_in_write,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_byte_valid,
    output logic [7:0]        o_byte,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word,
    output logic              o_overrun
);

    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_shift;
    logic              r_hold_valid;
    logic [7:0]        r_hold_data;
    logic              w_shift;

    // A held byte is always older than a byte arriving this cycle, so it is presented first.
    assign o_byte_valid = !i_in_write && (r_hold_valid || i_rx_valid);
    assign o_byte       = r_hold_valid ? r_hold_data : i_rx_data;
    assign w_shift      = i_shift_en && o_byte_valid;
    assign o_word       = {o_byte, r_shift[WORD_W-1:8]};
    assign o_word_valid = w_shift && (r_cnt == 2'd3);
    assign o_overrun    = i_in_write && i_rx_valid && r_hold_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= 2'd0;
            r_shift      <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= 8'd0;
        end else begin
            if (i_clear) begin
                r_cnt <= 2'd0;
            end else if (w_shift) begin
                r_cnt   <= r_cnt + 2'd1;
                r_shift <= o_word;
            end

            // Outside WRITE the held byte drains every cycle, re-filling if a new byte lands.
            if (i_flush) begin
                r_hold_valid <= 1'b0;
            end else if (i_rx_valid && (i_in_write ? !r_hold_valid : r_hold_valid)) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= i_rx_data;
            end else if (!i_in_write) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - frames UART bytes into instruction-memory writes and releases the CPU on a good checksum
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         TIMEOUT   = 270000,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    output logic              o_cpu_enable,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_error
);

    localparam int                 TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [LEN_W:0]     MAX_LEN  = (LEN_W + 1)'(2 ** ADDR_W);

    boot_state_t       r_state;
    boot_state_t       w_next;
    logic [7:0]        r_len_lo;
    logic [7:0]        r_csum;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_word_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              r_cpu_enable;
    logic              r_cpu_reset;
    logic              r_busy;
    logic              r_error;

    logic              w_byte_valid;
    logic [7:0]        w_byte;
    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;
    logic              w_overrun;
    logic [LEN_W-1:0]  w_len;
    logic              w_active;
    logic              w_timeout;
    logic              w_last_word;
    logic              w_enter_len;
    logic              w_wrote;

    boot_word_assembler u_assembler (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_enter_len),
        .i_flush      (w_next == ERROR),
        .i_shift_en   (r_state == DATA),
        .i_in_write   (r_state == WRITE),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_overrun    (w_overrun)
    );

    assign w_len       = {w_byte, r_len_lo};
    assign w_active    = in_frame(r_state);
    assign w_timeout   = w_active && !i_rx_valid && (r_tmo_cnt == TMO_LAST);
    assign w_last_word = (r_word_cnt + LEN_W'(1)) == r_len;
    assign w_enter_len = (w_next == LEN_LO) && (r_state != LEN_LO);
    assign w_wrote     = (r_state == WRITE) && ((w_next == DATA) || (w_next == CHECK));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, RUN, ERROR: begin
                if (w_byte_valid && (w_byte == SYNC_BYTE)) w_next = LEN_LO;
            end
            LEN_LO: begin
                if (w_byte_valid) w_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_byte_valid) begin
                    if (w_len == '0)                   w_next = CHECK;
                    else if ({1'b0, w_len} > MAX_LEN)  w_next = ERROR;
                    else                               w_next = DATA;
                end
            end
            DATA: begin
                if (w_word_valid) w_next = WRITE;
            end
            WRITE: begin
                if (w_overrun)      w_next = ERROR;
                else if (i_mem_ack) w_next = w_last_word ? CHECK : DATA;
            end
            CHECK: begin
                if (w_byte_valid) w_next = (w_byte == r_csum) ? RUN : ERROR;
            end
            default: w_next = IDLE;
        endcase
        if (w_timeout) w_next = ERROR;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_len_lo     <= 8'd0;
            r_csum       <= 8'd0;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_enable <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_enter_len) begin
                r_csum     <= 8'd0;
                r_word_cnt <= '0;
                r_mem_addr <= '0;
            end else begin
                if (w_byte_valid && ((r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA)))
                    r_csum <= r_csum + w_byte;
                if (w_wrote) r_word_cnt <= r_word_cnt + LEN_W'(1);
                // The address stays on the final word so it never wraps past 2**ADDR_W-1.
                if ((r_state == WRITE) && (w_next == DATA)) r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end

            if ((r_state == LEN_LO) && w_byte_valid) r_len_lo <= w_byte;
            if ((r_state == LEN_HI) && w_byte_valid) r_len <= w_len;
            if (w_word_valid) r_mem_wdata <= w_word;

            if (!w_active || i_rx_valid) r_tmo_cnt <= '0;
            else                         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

            r_mem_req    <= (w_next == WRITE);
            r_cpu_enable <= (w_next == RUN);
            r_cpu_reset  <= (w_next != RUN);
            r_busy       <= in_frame(w_next);

            if (w_next == ERROR)  r_error <= 1'b1;
            else if (w_enter_len) r_error <= 1'b0;
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_cpu_enable = r_cpu_enable;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_busy       = r_busy;
    assign o_error      = r_error;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed and randomized frame bench for uart_boot_loader
module tb_uart_boot_loader;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              mem_ack = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_enable;
    logic              cpu_reset;
    logic              busy;
    logic              error;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    bit ack_hold = 1'b0;
    int ack_wait = 0;
    int req_cycles = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [7:0]        frame_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];

    uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .SYNC_BYTE(8'hA5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_ack    (mem_ack),
        .o_cpu_enable (cpu_enable),
        .o_cpu_reset  (cpu_reset),
        .o_busy       (busy),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    // Memory model: acks after ack_delay cycles of request, logs every accepted write.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            ack_wait = 0;
        end else if (mem_req && !mem_ack && !ack_hold) begin
            if (ack_wait >= ack_delay) begin
                mem_ack = 1'b1;
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end else if (!mem_req || mem_ack) begin
            mem_ack = 1'b0;
            ack_wait = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_req) req_cycles++;
        if (rst_n && mem_req && mem_ack) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic build_frame(input int len, input bit bad_cs);
        int unsigned sum;
        logic [31:0] word;
        frame_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(len[7:0]);
        frame_q.push_back(len[15:8]);
        sum = len[7:0] + len[15:8];
        for (int w = 0; w < len; w++) begin
            word = $urandom;
            exp_addr_q.push_back(ADDR_W'(w));
            exp_data_q.push_back(word);
            for (int k = 0; k < 4; k++) begin
                frame_q.push_back(word[8*k +: 8]);
                sum += word[8*k +: 8];
            end
        end
        frame_q.push_back(8'((sum % 256) + (bad_cs ? 1 : 0)));
    endtask

    task automatic send_frame(input int gmin, input int gmax);
        foreach (frame_q[i]) send_byte(frame_q[i], int'($urandom_range(gmax, gmin)));
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, wr_addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
            chk({tag, "_wr_addr"}, wr_addr_q[i], exp_addr_q[i]);
            chk({tag, "_wr_data"}, wr_data_q[i], exp_data_q[i]);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic expect_state(input string tag, input logic en, input logic crst,
                                input logic bsy, input logic err);
        chk({tag, "_cpu_enable"}, cpu_enable, en);
        chk({tag, "_cpu_reset"}, cpu_reset, crst);
        chk({tag, "_busy"}, busy, bsy);
        chk({tag, "_error"}, error, err);
    endtask

    task automatic expect_reset_values(input string tag);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        expect_state(tag, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!mem_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, mem_req, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 expect_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reference frame with a good checksum
        ack_delay = 0;
        frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        exp_addr_q = {10'd0, 10'd1};
        exp_data_q = {32'h0000_0013, 32'h0010_0093};
        send_frame(2, 2);
        repeat (4) @(negedge clk);
        check_writes("good");
        expect_state("good", 1'b1, 1'b0, 1'b0, 1'b0);

        // Same frame, checksum off by one
        frame_q[11] = 8'hB9;
        send_frame(2, 2);
        repeat (4) @(negedge clk);
        check_writes("badcs");
        expect_state("badcs", 1'b0, 1'b1, 1'b0, 1'b1);

        build_frame(3, 1'b0);
        send_frame(2, 4);
        repeat (6) @(negedge clk);
        check_writes("recover");
        expect_state("recover", 1'b1, 1'b0, 1'b0, 1'b0);

        // Length one past the memory size
        req_cycles = 0;
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h04, 0);
        expect_state("toolong", 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("toolong_no_req", req_cycles, 0);

        // Overrun: two bytes arrive while the write is stalled
        ack_hold = 1'b1;
        send_byte(8'hA5, 2);
        chk("overrun_err_cleared", error, 1'b0);
        send_byte(8'h02, 2);
        send_byte(8'h00, 2);
        for (int k = 0; k < 4; k++) send_byte(8'(k + 1), 2);
        wait_req("overrun", 20);
        send_byte(8'h55, 10);
        chk("overrun_first_err", error, 1'b0);
        chk("overrun_first_req", mem_req, 1'b1);
        send_byte(8'h66, 0);
        chk("overrun_err", error, 1'b1);
        chk("overrun_req_drop", mem_req, 1'b0);
        chk("overrun_addr", mem_addr, '0);
        chk("overrun_busy", busy, 1'b0);
        repeat (25) @(negedge clk);
        ack_hold = 1'b0;
        chk("overrun_no_write", wr_addr_q.size(), 0);

        // Inter-byte timeout
        send_byte(8'hA5, 2);
        send_byte(8'h02, 2);
        send_byte(8'h00, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("tmo_early_err", error, 1'b0);
        chk("tmo_early_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        chk("tmo_err", error, 1'b1);
        chk("tmo_busy", busy, 1'b0);

        // Empty frame
        build_frame(0, 1'b0);
        send_frame(2, 3);
        repeat (3) @(negedge clk);
        check_writes("len0");
        expect_state("len0", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reload from RUN
        send_byte(8'hA5, 0);
        expect_state("reload_sync", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        exp_addr_q = {10'd0};
        exp_data_q = {32'd0};
        send_frame(2, 2);
        repeat (4) @(negedge clk);
        check_writes("reload");
        expect_state("reload", 1'b1, 1'b0, 1'b0, 1'b0);

        // Random frames, some with a corrupted checksum
        for (int f = 0; f < 8; f++) begin
            bit bad;
            bad = ($urandom_range(3, 0) == 0);
            ack_delay = int'($urandom_range(1, 0));
            build_frame(int'($urandom_range(8, 1)), bad);
            send_frame(2, 5);
            repeat (6) @(negedge clk);
            check_writes("rand");
            expect_state("rand", !bad, bad, 1'b0, bad);
        end

        // Largest legal frame fills the whole address space
        ack_delay = 0;
        build_frame(1 << ADDR_W, 1'b0);
        send_frame(1, 1);
        repeat (4) @(negedge clk);
        chk("max_last_addr", wr_addr_q.size() > 0 ? 32'(wr_addr_q[$]) : 32'hFFFF_FFFF, (1 << ADDR_W) - 1);
        check_writes("max");
        expect_state("max", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset pulled while a write is pending
        ack_hold = 1'b1;
        build_frame(2, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(frame_q[i], 2);
        wait_req("rstwr", 20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 expect_reset_values("rstwr_async");
        ack_hold = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_reset_values("rstwr_after");
        chk("rstwr_no_write", wr_addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
